dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arb_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_WAIT = 2'd2
    } arb_state_e;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    localparam int STARVE_MAX_DEF = 8;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection for the two requesters: starvation override first,
// then the tie-break pointer when both ports request.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pointer,
    input  logic       starve,
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        if (starve && req[PORT1]) begin
            winner = 2'b10;
        end else if (req == 2'b11) begin
            winner = pointer ? 2'b10 : 2'b01;
        end else begin
            winner = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: pipeline MEM stage (port 0) and loader/DMA (port 1).
// Define DMEM_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority with a p1 starvation guard.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_sel;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [1:0]        w_req;
    logic [1:0]        w_winner;
    logic [1:0]        w_gnt;
    logic              w_pointer;
    logic              w_starve;
    logic              w_capture;

    assign w_req = {p1_req, p0_req};

    dmem_arb_pick u_pick (
        .req     (w_req),
        .pointer (w_pointer),
        .starve  (w_starve),
        .winner  (w_winner)
    );

    // Grant is combinational from req; gating with rst keeps it low while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 2'b00;
        w_capture   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst && (w_winner != 2'b00)) begin
                    w_gnt       = w_winner;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_read    = ~r_we;
                mem_write   = r_we;
                w_state_nxt = r_we ? ST_IDLE : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_gnt != 2'b00) begin
            r_sel   <= w_gnt[PORT1];
            r_we    <= w_gnt[PORT1] ? p1_we : p0_we;
            r_addr  <= (w_gnt[PORT1] ? p1_addr : p0_addr) & ALIGN_MASK;
            r_wdata <= w_gnt[PORT1] ? p1_wdata : p0_wdata;
        end
    end

    // mem_rd is only looked at in RD_WAIT, so undriven bus values never land in rdata.
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_capture && !r_sel;
            r_rvalid1 <= w_capture && r_sel;
            if (w_capture && !r_sel) begin
                r_rdata0 <= mem_rd;
            end
            if (w_capture && r_sel) begin
                r_rdata1 <= mem_rd;
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    logic r_pointer;

    // Pointer names the port that wins the next tie: the one not granted last.
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            r_pointer <= 1'b0;
        end else if (w_gnt != 2'b00) begin
            r_pointer <= ~w_gnt[PORT1];
        end
    end

    assign w_pointer = r_pointer;
    assign w_starve  = 1'b0;
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_starve_cnt;

    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (w_gnt[PORT1]) begin
            r_starve_cnt <= '0;
        end else if (w_gnt[PORT0] && p1_req) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    assign w_pointer = 1'b0;
    assign w_starve  = (r_starve_cnt == CNT_W'(STARVE_MAX));
`endif

    assign p0_gnt    = w_gnt[PORT0];
    assign p1_gnt    = w_gnt[PORT1];
    assign p0_rvalid = r_rvalid0;
    assign p1_rvalid = r_rvalid1;
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;
    assign mem_addr  = r_addr;
    assign mem_wd    = r_wdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: randomized and directed requests,
// a grant-order reference model, and queue-based scoreboards for memory and read data.
module tb_dmem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 8;

    // ---------------- clock / reset ----------------
    logic clk_50 = 1'b0;
    logic rst    = 1'b0;
    always #5 clk_50 = ~clk_50;

    int cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    logic              p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
    logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
    logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_read, mem_write, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd, mem_rd;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_50(clk_50), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
    );

    // ---------------- memory environment ----------------
    // Registered-read RAM; when not returning data it drives random junk in place of Z/X.
    logic [31:0] bmem [0:63];
    logic [31:0] rd_q = '0;
    logic [31:0] junk = '0;
    logic        rd_v = 1'b0;
    always @(posedge clk_50) begin
        if (mem_write) bmem[mem_addr[7:2]] <= mem_wd;
        rd_v <= mem_read;
        if (mem_read) rd_q <= bmem[mem_addr[7:2]];
        junk <= $urandom;
    end
    assign mem_rd = rd_v ? rd_q : junk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rv_t;

    acc_t        acc_q[$];
    rv_t         rv0_q[$];
    rv_t         rv1_q[$];
    logic [31:0] ref_mem [0:63];
    int          dut_seq[$];
    logic [1:0]  g_last = 2'b00;
    int          free_at = 0;
    int          m_starve = 0;
    int          m_ptr = 0;

    // ---------------- reference model ----------------
    // One access at a time in grant order; a read keeps the block for 3 cycles, a write for 2.
    always @(negedge clk_50) begin
        logic [1:0]  rq;
        logic [1:0]  eg;
        int          w;
        acc_t        a;
        rv_t         r;
        g_last = {p1_gnt, p0_gnt};
        if (!rst) begin
            free_at  = 0;
            m_starve = 0;
            m_ptr    = 0;
            acc_q.delete();
            rv0_q.delete();
            rv1_q.delete();
        end else begin
            rq = {p1_req, p0_req};
            eg = 2'b00;
            check("busy", 64'(busy), 64'(cyc < free_at));
            if (p0_gnt || p1_gnt) dut_seq.push_back(int'(p1_gnt));
            if (cyc >= free_at && rq != 2'b00) begin
`ifdef DMEM_ARB_RR_EN
                if (rq == 2'b11) w = m_ptr;
                else w = rq[1] ? 1 : 0;
                m_ptr = 1 - w;
`else
                if (rq[1] && m_starve == STARVE_MAX) w = 1;
                else if (rq[0]) w = 0;
                else w = 1;
                if (w == 1) m_starve = 0;
                else if (rq[1]) m_starve++;
`endif
                eg[w]  = 1'b1;
                a.cyc  = cyc + 1;
                a.we   = (w == 1) ? p1_we : p0_we;
                a.addr = ((w == 1) ? p1_addr : p0_addr) & ~32'h3;
                a.data = (w == 1) ? p1_wdata : p0_wdata;
                acc_q.push_back(a);
                if (a.we) begin
                    ref_mem[a.addr[7:2]] = a.data;
                    free_at = cyc + 2;
                end else begin
                    free_at = cyc + 3;
                    r.cyc   = cyc + 3;
                    r.data  = ref_mem[a.addr[7:2]];
                    if (w == 1) rv1_q.push_back(r);
                    else rv0_q.push_back(r);
                end
            end
            check("gnt", 64'({p1_gnt, p0_gnt}), 64'(eg));
        end
    end

    // ---------------- monitors ----------------
    always @(negedge clk_50) begin
        acc_t a;
        if (rst && (mem_read || mem_write)) begin
            check("mem_rw_excl", 64'(mem_read & mem_write), 64'(0));
            if (acc_q.size() == 0) begin
                check("mem_unexpected", 64'({mem_read, mem_write}), 64'(0));
            end else begin
                a = acc_q.pop_front();
                check("mem_cycle", 64'(cyc), 64'(a.cyc));
                check("mem_write", 64'(mem_write), 64'(a.we));
                check("mem_addr", 64'(mem_addr), 64'(a.addr));
                if (a.we) check("mem_wd", 64'(mem_wd), 64'(a.data));
            end
        end
    end

    logic [31:0] exp_rd0 = '0;
    logic [31:0] exp_rd1 = '0;
    always @(negedge clk_50) begin
        rv_t r;
        if (!rst) begin
            check("reset_ctl", 64'({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_read, mem_write, busy}), 64'(0));
            check("reset_data", 64'(mem_addr | mem_wd | p0_rdata | p1_rdata), 64'(0));
            exp_rd0 = '0;
            exp_rd1 = '0;
        end else begin
            if (p0_rvalid) begin
                if (rv0_q.size() == 0) check("p0_rvalid_unexp", 64'(p0_rvalid), 64'(0));
                else begin
                    r = rv0_q.pop_front();
                    check("p0_rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    exp_rd0 = r.data;
                end
            end
            if (p1_rvalid) begin
                if (rv1_q.size() == 0) check("p1_rvalid_unexp", 64'(p1_rvalid), 64'(0));
                else begin
                    r = rv1_q.pop_front();
                    check("p1_rvalid_cycle", 64'(cyc), 64'(r.cyc));
                    exp_rd1 = r.data;
                end
            end
            check("p0_rdata", 64'(p0_rdata), 64'(exp_rd0));
            check("p1_rdata", 64'(p1_rdata), 64'(exp_rd1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic clr_req(input int p);
        if (p == 0) p0_req = 1'b0;
        else p1_req = 1'b0;
    endtask

    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        set_req(p, we, a, d);
        for (n = 0; n < 60; n++) begin
            step();
            if (g_last[p]) break;
        end
        if (n == 60) check("issue_timeout", 64'(g_last[p]), 64'(1));
        clr_req(p);
    endtask

    task automatic rand_phase(input int ncyc, input int p_new, input int p_wd);
        for (int i = 0; i < ncyc; i++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                logic held;
                held = (p == 0) ? p0_req : p1_req;
                if (g_last[p] || !held) begin
                    if ($urandom_range(99) < p_new)
                        set_req(p, 1'($urandom_range(1)), 32'($urandom_range(255)), $urandom);
                    else
                        clr_req(p);
                end else if ($urandom_range(99) < p_wd) begin
                    clr_req(p);
                end
            end
        end
        clr_req(0);
        clr_req(1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int exp_w;
        for (int i = 0; i < 64; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (i == 0) v = 32'd9;
            bmem[i]    <= v;
            ref_mem[i]  = v;
        end
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();

        // p0 read of word 0 alone
        issue(0, 1'b0, 32'h0, 32'h0);
        repeat (4) step();

        // p1 write to an unaligned address, then read back the aligned word
        issue(1, 1'b1, 32'h13, 32'h55);
        repeat (3) step();
        issue(1, 1'b0, 32'h10, 32'h0);
        repeat (4) step();

        // p0 request withdrawn while p1 is being served
        set_req(1, 1'b0, 32'h24, 32'h0);
        step();
        clr_req(1);
        set_req(0, 1'b1, 32'h30, 32'hABCD);
        step();
        step();
        clr_req(0);
        repeat (5) step();

        rand_phase(300, 60, 10);
        repeat (5) step();

        // reset while a p0 read sits in RD_WAIT, with p0_req held high during reset
        issue(0, 1'b0, 32'h8, 32'h0);
        step();
        rst = 1'b0;
        set_req(0, 1'b0, 32'h4, 32'h0);
        repeat (3) step();
        clr_req(0);
        rst = 1'b1;
        step();
        issue(1, 1'b0, 32'h20, 32'h0);
        repeat (4) step();

        // both ports requesting back to back: check the grant order
        dut_seq.delete();
        rand_phase(80, 100, 0);
        repeat (5) step();
        check("pattern_len", 64'(dut_seq.size() >= 18), 64'(1));
        for (int i = 0; i < 18 && i < dut_seq.size(); i++) begin
`ifdef DMEM_ARB_RR_EN
            exp_w = i % 2;
`else
            exp_w = (i % (STARVE_MAX + 1) == STARVE_MAX) ? 1 : 0;
`endif
            check("grant_pattern", 64'(dut_seq[i]), 64'(exp_w));
        end

        rand_phase(400, 50, 15);
        repeat (8) step();
        check("acc_q_drained", 64'(acc_q.size()), 64'(0));
        check("rv0_q_drained", 64'(rv0_q.size()), 64'(0));
        check("rv1_q_drained", 64'(rv1_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
